// File: rtl/id_stage.sv
// id_stage: RV32I decode stage for the ALU-class instructions (OP, OP-IMM, LUI,
// AUIPC). It holds the 32x32 register file, the decoder and the ID/EX register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   if_valid/instr/pc fetched instruction and its PC
//   stall, flush      ID/EX hold / bubble controls (flush has priority)
//   wb_en/rd/data     register-file write port from writeback
//   id_ready          combinational, equals !stall
//   ex_*              registered ID/EX payload for the execute-stage ALU

package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

package id_stage_pkg;
    import alu_pkg::*;

    // ID/EX register payload
    typedef struct packed {
        logic        valid;
        alu_op_t     op;
        logic [31:0] opr_a;
        logic [31:0] opr_b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:   1'b0,
        op:      ALU_ADD,
        opr_a:   32'd0,
        opr_b:   32'd0,
        rd:      5'd0,
        rd_we:   1'b0,
        illegal: 1'b0
    };
endpackage

module id_stage
    import alu_pkg::*;
    import id_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    input  logic [31:0]        if_pc,
    input  logic               stall,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [31:0]        wb_data,
    output logic               id_ready,
    output logic               ex_valid,
    output alu_op_t            ex_op,
    output logic signed [31:0] ex_opr_a,
    output logic signed [31:0] ex_opr_b,
    output logic [4:0]         ex_rd,
    output logic               ex_rd_we,
    output logic               ex_illegal
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREG    = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];
    assign imm_i  = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_u  = {if_instr[31:12], 12'b0};

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    alu_op_t         dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_legal;
    id_ex_t          dec;
    id_ex_t          ex_q;

    // Register file: x0 is never written; reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Read ports with same-cycle writeback bypass; x0 always reads zero
    always_comb begin
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
        if (rs1 == 5'd0) begin
            rs1_data = '0;
        end else if (wb_en && (wb_rd == rs1)) begin
            rs1_data = wb_data;
        end
        if (rs2 == 5'd0) begin
            rs2_data = '0;
        end else if (wb_en && (wb_rd == rs2)) begin
            rs2_data = wb_data;
        end
    end

    // Operation and operand selection
    always_comb begin
        dec_op    = ALU_ADD;
        dec_a     = '0;
        dec_b     = '0;
        dec_legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = ALU_ADD;
                            dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_op    = ALU_SUB;
                            dec_legal = 1'b1;
                        end
                    end
                    F3_SR: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = ALU_SRL;
                            dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_op    = ALU_SRA;
                            dec_legal = 1'b1;
                        end
                    end
                    default: begin
                        dec_legal = (funct7 == F7_BASE);
                        case (funct3)
                            F3_SLL:  dec_op = ALU_SLL;
                            F3_SLT:  dec_op = ALU_SLT;
                            F3_SLTU: dec_op = ALU_SLTU;
                            F3_XOR:  dec_op = ALU_XOR;
                            F3_OR:   dec_op = ALU_OR;
                            F3_AND:  dec_op = ALU_AND;
                            default: dec_op = ALU_ADD;
                        endcase
                    end
                endcase
            end
            OPC_OP_IMM: begin
                dec_a = rs1_data;
                dec_b = imm_i;
                case (funct3)
                    F3_ADD:  begin dec_op = ALU_ADD;  dec_legal = 1'b1; end
                    F3_SLT:  begin dec_op = ALU_SLT;  dec_legal = 1'b1; end
                    F3_SLTU: begin dec_op = ALU_SLTU; dec_legal = 1'b1; end
                    F3_XOR:  begin dec_op = ALU_XOR;  dec_legal = 1'b1; end
                    F3_OR:   begin dec_op = ALU_OR;   dec_legal = 1'b1; end
                    F3_AND:  begin dec_op = ALU_AND;  dec_legal = 1'b1; end
                    F3_SLL: begin
                        dec_op    = ALU_SLL;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    default: begin
                        if (funct7 == F7_BASE) begin
                            dec_op    = ALU_SRL;
                            dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_op    = ALU_SRA;
                            dec_legal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                dec_op    = ALU_ADD;
                dec_a     = '0;
                dec_b     = imm_u;
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op    = ALU_ADD;
                dec_a     = if_pc;
                dec_b     = imm_u;
                dec_legal = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        // ALU shifts by the full operand, so keep only the 5-bit shift amount
        if ((dec_op == ALU_SLL) || (dec_op == ALU_SRL) || (dec_op == ALU_SRA)) begin
            dec_b = {(XLEN-SHAMT_W)'(0), dec_b[SHAMT_W-1:0]};
        end
    end

    // Assemble ID/EX payload; illegal encodings become a flagged no-op
    always_comb begin
        dec = ID_EX_BUBBLE;
        dec.valid = 1'b1;
        if (dec_legal) begin
            dec.op    = dec_op;
            dec.opr_a = dec_a;
            dec.opr_b = dec_b;
            dec.rd    = rd;
            dec.rd_we = (rd != 5'd0);
        end else begin
            dec.illegal = 1'b1;
        end
    end

    // ID/EX register: flush > stall > load > bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= ID_EX_BUBBLE;
        end else if (flush) begin
            ex_q <= ID_EX_BUBBLE;
        end else if (stall) begin
            ex_q <= ex_q;
        end else if (if_valid) begin
            ex_q <= dec;
        end else begin
            ex_q <= ID_EX_BUBBLE;
        end
    end

    assign id_ready   = !stall;
    assign ex_valid   = ex_q.valid;
    assign ex_op      = ex_q.op;
    assign ex_opr_a   = ex_q.opr_a;
    assign ex_opr_b   = ex_q.opr_b;
    assign ex_rd      = ex_q.rd;
    assign ex_rd_we   = ex_q.rd_we;
    assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed stimulus for id_stage with a behavioural reference
// model (register array + rule-based decode) compared every cycle, plus
// literal expectations for the key instructions.
`timescale 1ns/1ps
module tb_id_stage;
    import alu_pkg::*;

    logic               clk;
    logic               rst;
    logic               if_valid;
    logic [31:0]        if_instr;
    logic [31:0]        if_pc;
    logic               stall;
    logic               flush;
    logic               wb_en;
    logic [4:0]         wb_rd;
    logic [31:0]        wb_data;
    logic               id_ready;
    logic               ex_valid;
    alu_op_t            ex_op;
    logic signed [31:0] ex_opr_a;
    logic signed [31:0] ex_opr_b;
    logic [4:0]         ex_rd;
    logic               ex_rd_we;
    logic               ex_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .stall      (stall),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .id_ready   (id_ready),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_opr_a   (ex_opr_a),
        .ex_opr_b   (ex_opr_b),
        .ex_rd      (ex_rd),
        .ex_rd_we   (ex_rd_we),
        .ex_illegal (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic [31:0] m_rf [32];
    exp_t        m_ex;

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 1'b0; e.op = ALU_ADD; e.a = 0; e.b = 0;
        e.rd = 0; e.we = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic exp_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
        alu_op_t base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        logic       alt = (f7 == 7'h20);
        logic       ok  = 1'b0;
        exp_t e = bubble();
        e.valid = 1'b1;
        case (ins[6:0])
            7'h33: begin
                ok   = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
                e.op = base[f3];
                if (alt) e.op = (f3 == 0) ? ALU_SUB : ALU_SRA;
                e.a = m_read(ins[19:15]);
                e.b = m_read(ins[24:20]);
            end
            7'h13: begin
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 0) || alt;
                else ok = 1'b1;
                e.op = base[f3];
                if (f3 == 5 && alt) e.op = ALU_SRA;
                e.a = m_read(ins[19:15]);
                e.b = {{20{ins[31]}}, ins[31:20]};
            end
            7'h37: begin ok = 1'b1; e.op = ALU_ADD; e.a = 0;  e.b = ins & 32'hFFFF_F000; end
            7'h17: begin ok = 1'b1; e.op = ALU_ADD; e.a = pc; e.b = ins & 32'hFFFF_F000; end
            default: ok = 1'b0;
        endcase
        if (e.op == ALU_SLL || e.op == ALU_SRL || e.op == ALU_SRA) e.b = e.b % 32;
        if (!ok) begin
            e = bubble();
            e.valid = 1'b1;
            e.ill   = 1'b1;
        end else begin
            e.rd = ins[11:7];
            e.we = (ins[11:7] != 0);
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            m_ex = bubble();
        end else begin
            if (flush)         m_ex = bubble();
            else if (stall)    m_ex = m_ex;
            else if (if_valid) m_ex = m_decode(if_instr, if_pc);
            else               m_ex = bubble();
            if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("cyc_ready",   32'(id_ready),   32'(!stall));
        chk("cyc_valid",   32'(ex_valid),   32'(m_ex.valid));
        chk("cyc_op",      32'(ex_op),      32'(m_ex.op));
        chk("cyc_a",       ex_opr_a,        m_ex.a);
        chk("cyc_b",       ex_opr_b,        m_ex.b);
        chk("cyc_rd",      32'(ex_rd),      32'(m_ex.rd));
        chk("cyc_rd_we",   32'(ex_rd_we),   32'(m_ex.we));
        chk("cyc_illegal", 32'(ex_illegal), 32'(m_ex.ill));
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
        if_valid = v; if_instr = ins; if_pc = pc;
        stall = st; flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_only(input logic [4:0] wr, input logic [31:0] wd);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, wr, wd);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"},   32'(ex_valid),   32'd0);
        chk({tag, "_op"},      32'(ex_op),      32'(ALU_ADD));
        chk({tag, "_a"},       ex_opr_a,        32'd0);
        chk({tag, "_b"},       ex_opr_b,        32'd0);
        chk({tag, "_rd"},      32'(ex_rd),      32'd0);
        chk({tag, "_rd_we"},   32'(ex_rd_we),   32'd0);
        chk({tag, "_illegal"}, 32'(ex_illegal), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 0; if_instr = 0; if_pc = 0;
        stall = 0; flush = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        #3;
        chk_bubble("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Register setup
        wb_only(5'd5, 32'd7);
        wb_only(5'd6, 32'd3);
        wb_only(5'd1, 32'd1);
        wb_only(5'd10, 32'h23);

        // sub x7,x5,x6 with same-cycle WB x6=10
        step(1'b1, r_type(7'h20, 5'd6, 5'd5, 3'd0, 5'd7, 7'h33), 32'd0, 0, 0, 1'b1, 5'd6, 32'd10);
        chk("sub_op", 32'(ex_op), 32'(ALU_SUB));
        chk("sub_a", ex_opr_a, 32'd7);
        chk("sub_b", ex_opr_b, 32'd10);
        chk("sub_rd", 32'(ex_rd), 32'd7);
        chk("sub_we", 32'(ex_rd_we), 32'd1);

        // addi x2,x1,-1
        step(1'b1, i_type(12'hFFF, 5'd1, 3'd0, 5'd2, 7'h13), 32'd4, 0, 0, 0, 5'd0, 32'd0);
        chk("addi_op", 32'(ex_op), 32'(ALU_ADD));
        chk("addi_a", ex_opr_a, 32'd1);
        chk("addi_b", ex_opr_b, 32'hFFFF_FFFF);

        // srai x3,x1,31
        step(1'b1, i_type(12'h41F, 5'd1, 3'd5, 5'd3, 7'h13), 32'd8, 0, 0, 0, 5'd0, 32'd0);
        chk("srai_op", 32'(ex_op), 32'(ALU_SRA));
        chk("srai_b", ex_opr_b, 32'd31);

        // lui x4,0xABCDE
        step(1'b1, u_type(20'hABCDE, 5'd4, 7'h37), 32'd12, 0, 0, 0, 5'd0, 32'd0);
        chk("lui_op", 32'(ex_op), 32'(ALU_ADD));
        chk("lui_a", ex_opr_a, 32'd0);
        chk("lui_b", ex_opr_b, 32'hABCD_E000);

        // auipc x8,1 at pc=0x100
        step(1'b1, u_type(20'h00001, 5'd8, 7'h17), 32'h100, 0, 0, 0, 5'd0, 32'd0);
        chk("auipc_a", ex_opr_a, 32'h100);
        chk("auipc_b", ex_opr_b, 32'h1000);

        // sll x9,x1,x10 with x10=0x23
        step(1'b1, r_type(7'h00, 5'd10, 5'd1, 3'd1, 5'd9, 7'h33), 32'h104, 0, 0, 0, 5'd0, 32'd0);
        chk("sll_op", 32'(ex_op), 32'(ALU_SLL));
        chk("sll_b", ex_opr_b, 32'd3);

        // Load opcode is illegal here
        step(1'b1, i_type(12'd0, 5'd1, 3'd0, 5'd5, 7'h03), 32'h108, 0, 0, 0, 5'd0, 32'd0);
        chk("ld_valid", 32'(ex_valid), 32'd1);
        chk("ld_ill", 32'(ex_illegal), 32'd1);
        chk("ld_we", 32'(ex_rd_we), 32'd0);
        chk("ld_a", ex_opr_a, 32'd0);

        // OP with funct7=0000001
        step(1'b1, r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33), 32'h10C, 0, 0, 0, 5'd0, 32'd0);
        chk("f7_ill", 32'(ex_illegal), 32'd1);
        chk("f7_we", 32'(ex_rd_we), 32'd0);

        // add x0,x1,x1
        step(1'b1, r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd0, 7'h33), 32'h110, 0, 0, 0, 5'd0, 32'd0);
        chk("x0_ill", 32'(ex_illegal), 32'd0);
        chk("x0_we", 32'(ex_rd_we), 32'd0);
        chk("x0_a", ex_opr_a, 32'd1);

        // WB to x0, then read x0 (same cycle and next cycle)
        step(1'b1, r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd11, 7'h33), 32'h114, 0, 0, 1'b1, 5'd0, 32'h55);
        chk("x0byp_a", ex_opr_a, 32'd0);
        step(1'b1, r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd11, 7'h33), 32'h118, 0, 0, 0, 5'd0, 32'd0);
        chk("x0rd_a", ex_opr_a, 32'd0);
        chk("x0rd_b", ex_opr_b, 32'd0);

        // Other ALU ops, modelled only
        step(1'b1, r_type(7'h00, 5'd6, 5'd5, 3'd6, 5'd13, 7'h33), 32'h11C, 0, 0, 0, 5'd0, 32'd0);
        step(1'b1, i_type(12'h805, 5'd5, 3'd3, 5'd14, 7'h13), 32'h120, 0, 0, 0, 5'd0, 32'd0);
        step(1'b1, i_type(12'h203, 5'd5, 3'd1, 5'd14, 7'h13), 32'h124, 0, 0, 0, 5'd0, 32'd0);

        // Stall for 3 cycles: outputs hold, operands not re-read
        step(1'b1, r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd12, 7'h33), 32'h128, 0, 0, 0, 5'd0, 32'd0);
        chk("pre_stall_a", ex_opr_a, 32'd7);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i_type(12'h001, 5'd1, 3'd0, 5'd2, 7'h13), 32'h12C, 1'b1, 0, 1'b1, 5'd5, 32'd99);
            chk("stall_ready", 32'(id_ready), 32'd0);
            chk("stall_a", ex_opr_a, 32'd7);
            chk("stall_b", ex_opr_b, 32'd10);
            chk("stall_rd", 32'(ex_rd), 32'd12);
        end
        step(1'b1, r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd12, 7'h33), 32'h128, 0, 0, 0, 5'd0, 32'd0);
        chk("unstall_ready", 32'(id_ready), 32'd1);
        chk("unstall_a", ex_opr_a, 32'd99);

        // Stall and flush together
        step(1'b1, r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd12, 7'h33), 32'h12C, 1'b1, 1'b1, 0, 5'd0, 32'd0);
        chk_bubble("flush");

        // Valid instruction, then if_valid=0
        step(1'b1, r_type(7'h00, 5'd6, 5'd5, 3'd4, 5'd15, 7'h33), 32'h130, 0, 0, 0, 5'd0, 32'd0);
        chk("xor_op", 32'(ex_op), 32'(ALU_XOR));
        step(1'b0, 32'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
        chk_bubble("novalid");

        // Asynchronous reset between edges
        step(1'b1, r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd16, 7'h33), 32'h134, 0, 0, 0, 5'd0, 32'd0);
        chk("prerst_valid", 32'(ex_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_bubble("midrst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, r_type(7'h00, 5'd0, 5'd5, 3'd0, 5'd13, 7'h33), 32'h200, 0, 0, 0, 5'd0, 32'd0);
        chk("postrst_a", ex_opr_a, 32'd0);
        chk("postrst_valid", 32'(ex_valid), 32'd1);

        step(1'b0, 32'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
